// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: requester indices, producer tags and small helpers
// used by the CDB arbiter and its round-robin picker.
package tomasulo_pkg;

  localparam int NUM_REQ = 6;
  localparam int TAG_W   = 4;
  localparam int PTR_W   = 3;
  localparam int STALL_W = 16;

  localparam int REQ_ADD1  = 0;
  localparam int REQ_ADD2  = 1;
  localparam int REQ_ADD3  = 2;
  localparam int REQ_MULT1 = 3;
  localparam int REQ_MULT2 = 4;
  localparam int REQ_LS    = 5;

  localparam logic [TAG_W-1:0] TAG_ADD1  = 4'd7;
  localparam logic [TAG_W-1:0] TAG_ADD2  = 4'd8;
  localparam logic [TAG_W-1:0] TAG_ADD3  = 4'd9;
  localparam logic [TAG_W-1:0] TAG_MULT1 = 4'd10;
  localparam logic [TAG_W-1:0] TAG_MULT2 = 4'd11;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [PTR_W-1:0]   ptr_t;

  // Buffer indices 0 and 7 are never valid load/store producers.
  function automatic logic ls_idx_legal(logic [2:0] idx);
    return (idx != 3'd0) && (idx != 3'd7);
  endfunction

  function automatic logic [TAG_W-1:0] producer_tag(int req, logic [2:0] ls_idx);
    case (req)
      REQ_ADD1:  producer_tag = TAG_ADD1;
      REQ_ADD2:  producer_tag = TAG_ADD2;
      REQ_ADD3:  producer_tag = TAG_ADD3;
      REQ_MULT1: producer_tag = TAG_MULT1;
      REQ_MULT2: producer_tag = TAG_MULT2;
      default:   producer_tag = {1'b0, ls_idx};
    endcase
  endfunction

  function automatic logic contended(req_vec_t eligible);
    return $countones(eligible) >= 2;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
// master = requester side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int DATA_W = 32
);

  logic [5:0]          req_valid;
  logic [6*DATA_W-1:0] req_data;
  logic [2:0]          ls_idx;
  logic                flush;
  logic [5:0]          req_grant;
  logic                cdb_valid;
  logic [3:0]          cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [15:0]         stall_cnt;

  modport master (
    output req_valid, req_data, ls_idx, flush,
    input  req_grant, cdb_valid, cdb_tag, cdb_data, stall_cnt
  );

  modport slave (
    input  req_valid, req_data, ls_idx, flush,
    output req_grant, cdb_valid, cdb_tag, cdb_data, stall_cnt
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin one-hot picker: first set request at or above ptr, wrapping 5->0.
// Only compiled into builds with CDB_ROUND_ROBIN_EN defined.
`ifdef CDB_ROUND_ROBIN_EN
module rr_picker
  import tomasulo_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W-1:0]     start;
  logic [2*NUM_REQ-1:0] req_rot_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   gnt_rot;
  logic [2*NUM_REQ-1:0] gnt_dbl;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
  assign start       = (ptr < PTR_W'(NUM_REQ)) ? ptr : '0;
  assign req_rot_dbl = {req, req} >> start;
  assign req_rot     = req_rot_dbl[NUM_REQ-1:0];
  assign gnt_rot     = req_rot & (~req_rot + NUM_REQ'(1));
  assign gnt_dbl     = {gnt_rot, gnt_rot} << start;
  assign grant       = gnt_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule
`endif

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one grant per cycle, registered broadcast one cycle later.
// Define CDB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  req_vec_t            eligible;
  req_vec_t            pick;
  req_vec_t            grant;
  logic                cdb_valid_q;
  logic [TAG_W-1:0]    cdb_tag_q;
  logic [DATA_W-1:0]   cdb_data_q;
  logic [STALL_W-1:0]  stall_q;
  logic [TAG_W-1:0]    sel_tag;
  logic [DATA_W-1:0]   sel_data;

  always_comb begin
    eligible         = bus.req_valid;
    eligible[REQ_LS] = bus.req_valid[REQ_LS] & ls_idx_legal(bus.ls_idx);
  end

`ifdef CDB_ROUND_ROBIN_EN
  ptr_t ptr_q;
  ptr_t ptr_nxt;

  rr_picker u_rr_picker (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (pick)
  );

  always_comb begin
    ptr_nxt = ptr_q;
    case (grant)
      6'b000001: ptr_nxt = 3'd1;
      6'b000010: ptr_nxt = 3'd2;
      6'b000100: ptr_nxt = 3'd3;
      6'b001000: ptr_nxt = 3'd4;
      6'b010000: ptr_nxt = 3'd5;
      6'b100000: ptr_nxt = 3'd0;
      default:   ptr_nxt = ptr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end
`else
  // Memory results first so loads unblock dependants soonest, then long-latency MULTs.
  always_comb begin
    pick = '0;
    if (eligible[REQ_LS])         pick[REQ_LS]    = 1'b1;
    else if (eligible[REQ_MULT1]) pick[REQ_MULT1] = 1'b1;
    else if (eligible[REQ_MULT2]) pick[REQ_MULT2] = 1'b1;
    else if (eligible[REQ_ADD1])  pick[REQ_ADD1]  = 1'b1;
    else if (eligible[REQ_ADD2])  pick[REQ_ADD2]  = 1'b1;
    else if (eligible[REQ_ADD3])  pick[REQ_ADD3]  = 1'b1;
  end
`endif

  assign grant         = (rst_n && !bus.flush) ? pick : '0;
  assign bus.req_grant = grant;

  // One-hot grant, so an OR chain of masked slices is the mux.
  logic [NUM_REQ:0][DATA_W-1:0] data_acc;
  logic [NUM_REQ:0][TAG_W-1:0]  tag_acc;

  assign data_acc[0] = '0;
  assign tag_acc[0]  = '0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
    assign data_acc[g+1] = data_acc[g] |
                           (grant[g] ? bus.req_data[g*DATA_W +: DATA_W] : '0);
    assign tag_acc[g+1]  = tag_acc[g] |
                           (grant[g] ? producer_tag(g, bus.ls_idx) : '0);
  end

  assign sel_data = data_acc[NUM_REQ];
  assign sel_tag  = tag_acc[NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      cdb_valid_q <= |grant;
      cdb_tag_q   <= sel_tag;
      cdb_data_q  <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!bus.flush && contended(eligible) && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-free reference model
// computed from the arbitration rules; honours CDB_ROUND_ROBIN_EN like the design.
module tb_cdb_arbiter;

  localparam int DW = 32;

  typedef struct packed {
    logic [5:0]    g;
    logic          cv;
    logic [3:0]    ct;
    logic [DW-1:0] cd;
    logic [15:0]   sc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ptr = 0;
  int   m_stall = 0;

  cdb_arbiter_if #(.DATA_W(DW)) bus ();

  cdb_arbiter #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] elig_of(logic [5:0] v, logic [2:0] ls);
    logic [5:0] e;
    e = v;
    if (ls == 3'd0 || ls == 3'd7) e[5] = 1'b0;
    return e;
  endfunction

  function automatic int pick(logic [5:0] e, int ptr);
`ifdef CDB_ROUND_ROBIN_EN
    for (int k = 0; k < 6; k++) begin
      if (e[(ptr + k) % 6]) return (ptr + k) % 6;
    end
`else
    int order [6];
    order = '{5, 3, 4, 0, 1, 2};
    for (int k = 0; k < 6; k++) begin
      if (e[order[k]]) return order[k];
    end
`endif
    return -1;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("g=%b v=%b tag=%0d data=%h stall=%0d", o.g, o.cv, o.ct, o.cd, o.sc);
  endfunction

  task automatic set_data(input int i, input logic [DW-1:0] val);
    bus.req_data[i*DW +: DW] = val;
  endtask

  // One clock: sample grant mid-cycle, predict, then sample registered outputs.
  task automatic run_cycle(output obs_t act_o, output obs_t exp_o);
    logic [5:0] e;
    int p;
    #1;
    act_o   = '0;
    exp_o   = '0;
    act_o.g = bus.req_grant;
    e = elig_of(bus.req_valid, bus.ls_idx);
    p = (rst_n === 1'b1 && bus.flush !== 1'b1) ? pick(e, m_ptr) : -1;
    if (p >= 0) begin
      exp_o.g[p] = 1'b1;
      exp_o.cv   = 1'b1;
      exp_o.ct   = (p == 5) ? {1'b0, bus.ls_idx} : 4'(7 + p);
      exp_o.cd   = bus.req_data[p*DW +: DW];
    end
    if (rst_n !== 1'b1) begin
      m_stall = 0;
      m_ptr   = 0;
    end else begin
      if (bus.flush !== 1'b1 && $countones(e) >= 2 && m_stall < 65535) m_stall++;
      if (bus.flush === 1'b1) m_ptr = 0;
      else if (p >= 0) m_ptr = (p + 1) % 6;
    end
    exp_o.sc = 16'(m_stall);
    @(posedge clk);
    #1;
    act_o.cv = bus.cdb_valid;
    act_o.ct = bus.cdb_tag;
    act_o.cd = bus.cdb_data;
    act_o.sc = bus.stall_cnt;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.ls_idx    = 3'd0;
    bus.flush     = 1'b0;
  endtask

  task automatic do_reset();
    obs_t a, e;
    clear_inputs();
    rst_n = 1'b0;
    run_cycle(a, e);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t a, e;
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.ls_idx    = 3'd3;
    bus.flush     = 1'b0;
    for (int i = 0; i < 6; i++) set_data(i, $urandom);
    for (int c = 0; c < 2; c++) begin
      run_cycle(a, e);
      n_vec++;
      if (a !== obs_t'(0)) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %s want all zero", c, fmt(a));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    obs_t a, e;
    do_reset();
    run_cycle(a, e);
    run_cycle(a, e);
    bus.req_valid = 6'b000010;
    for (int i = 0; i < 6; i++) set_data(i, $urandom);
    set_data(1, 32'h0000_00AA);
    run_cycle(a, e);
    n_vec++;
    if (a.g !== 6'b000010) begin
      n_err++;
      $display("FAIL single_grant: got %b want 000010", a.g);
    end
    n_vec++;
    if ({a.cv, a.ct, a.cd} !== {1'b1, 4'd8, 32'h0000_00AA}) begin
      n_err++;
      $display("FAIL single_bcast: got %s want v=1 tag=8 data=000000aa", fmt(a));
    end
    bus.req_valid = '0;
    run_cycle(a, e);
    n_vec++;
    if (a !== e || a.cv !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got %s want %s", fmt(a), fmt(e));
    end
  endtask

  task automatic test_all_six();
    obs_t a, e;
    int ord [6];
    int tag [6];
`ifdef CDB_ROUND_ROBIN_EN
    ord = '{0, 1, 2, 3, 4, 5};
    tag = '{7, 8, 9, 10, 11, 3};
`else
    ord = '{5, 3, 4, 0, 1, 2};
    tag = '{3, 10, 11, 7, 8, 9};
`endif
    do_reset();
    bus.req_valid = '1;
    bus.ls_idx    = 3'd3;
    for (int i = 0; i < 6; i++) set_data(i, $urandom);
    for (int k = 0; k < 6; k++) begin
      run_cycle(a, e);
      n_vec++;
      if (a !== e || a.g !== 6'(1 << ord[k]) || a.ct !== 4'(tag[k])) begin
        n_err++;
        $display("FAIL all_six step%0d: got %s want %s tag=%0d", k, fmt(a), fmt(e), tag[k]);
      end
      bus.req_valid[ord[k]] = 1'b0;
    end
    run_cycle(a, e);
    n_vec++;
    if (a.sc !== 16'd5 || a.cv !== 1'b0) begin
      n_err++;
      $display("FAIL all_six_stall: got %s want v=0 stall=5", fmt(a));
    end
  endtask

  task automatic test_illegal_ls();
    obs_t a, e;
    logic [15:0] sc0;
    sc0 = 16'(m_stall);
    bus.flush     = 1'b0;
    bus.req_valid = 6'b100000;
    for (int c = 0; c < 6; c++) begin
      bus.ls_idx = (c < 4) ? 3'd0 : 3'd7;
      run_cycle(a, e);
      n_vec++;
      if (a.g !== 6'b0 || a.cv !== 1'b0 || a.sc !== sc0) begin
        n_err++;
        $display("FAIL illegal_ls cyc%0d: got %s want g=0 v=0 stall=%0d", c, fmt(a), sc0);
      end
    end
    // An illegal LS alongside ADD1 is not contention.
    bus.req_valid = 6'b100001;
    set_data(0, 32'h1234_5678);
    run_cycle(a, e);
    n_vec++;
    if (a.g !== 6'b000001 || a.ct !== 4'd7 || a.cd !== 32'h1234_5678 || a.sc !== sc0) begin
      n_err++;
      $display("FAIL illegal_ls_mix: got %s want g=000001 tag=7 data=12345678 stall=%0d", fmt(a), sc0);
    end
    bus.req_valid = '0;
    run_cycle(a, e);
  endtask

  task automatic test_flush();
    obs_t a, e;
    do_reset();
    bus.req_valid = 6'b001100;
    set_data(2, 32'hAAAA_0003);
    set_data(3, 32'hBBBB_0004);
    bus.flush = 1'b1;
    run_cycle(a, e);
    n_vec++;
    if (a.g !== 6'b0 || a.cv !== 1'b0 || a.sc !== 16'd0) begin
      n_err++;
      $display("FAIL flush_cycle: got %s want g=0 v=0 stall=0", fmt(a));
    end
    bus.flush = 1'b0;
    run_cycle(a, e);
    n_vec++;
`ifdef CDB_ROUND_ROBIN_EN
    if (a.g !== 6'b000100 || a.ct !== 4'd9 || a.cd !== 32'hAAAA_0003 || a.sc !== 16'd1) begin
      n_err++;
      $display("FAIL flush_after: got %s want g=000100 tag=9 data=aaaa0003 stall=1", fmt(a));
    end
`else
    if (a.g !== 6'b001000 || a.ct !== 4'd10 || a.cd !== 32'hBBBB_0004 || a.sc !== 16'd1) begin
      n_err++;
      $display("FAIL flush_after: got %s want g=001000 tag=10 data=bbbb0004 stall=1", fmt(a));
    end
`endif
    bus.req_valid = '0;
    run_cycle(a, e);
  endtask

  task automatic test_reset_midstream();
    obs_t a, e;
    do_reset();
    bus.req_valid = '1;
    bus.ls_idx    = 3'd5;
    for (int i = 0; i < 6; i++) set_data(i, $urandom);
    for (int c = 0; c < 2; c++) begin
      run_cycle(a, e);
      bus.req_valid = bus.req_valid & ~e.g;
    end
    bus.req_valid = '1;
    rst_n = 1'b0;
    run_cycle(a, e);
    n_vec++;
    if (a.g !== 6'b0 || a.cv !== 1'b0 || a.sc !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %s want g=0 v=0 stall=0", fmt(a));
    end
    rst_n = 1'b1;
    run_cycle(a, e);
    n_vec++;
`ifdef CDB_ROUND_ROBIN_EN
    if (a !== e || a.g !== 6'b000001 || a.ct !== 4'd7) begin
      n_err++;
      $display("FAIL reset_restart: got %s want %s (ADD1)", fmt(a), fmt(e));
    end
`else
    if (a !== e || a.g !== 6'b100000 || a.ct !== 4'd5) begin
      n_err++;
      $display("FAIL reset_restart: got %s want %s (LS)", fmt(a), fmt(e));
    end
`endif
    bus.req_valid = '0;
    run_cycle(a, e);
  endtask

  task automatic test_random();
    obs_t a, e;
    logic [5:0] last_g;
    last_g = '0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 6; i++) begin
        if (last_g[i]) begin
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.req_valid[i] = 1'b1;
          set_data(i, $urandom);
          if (i == 5) bus.ls_idx = 3'($urandom_range(0, 7));
        end else if (i == 5 && bus.req_valid[5] && (bus.ls_idx == 3'd0 || bus.ls_idx == 3'd7)
                     && $urandom_range(0, 3) == 0) begin
          bus.req_valid[5] = 1'b0;
        end
      end
      bus.flush = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 249) != 0);
      run_cycle(a, e);
      last_g = e.g;
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL random cyc%0d: got %s want %s", n, fmt(a), fmt(e));
      end
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_saturation();
    obs_t a, e;
    do_reset();
    bus.req_valid = 6'b000011;
    for (int i = 0; i < 70000; i++) begin
      run_cycle(a, e);
      if (i == 65533) begin
        n_vec++;
        if (a.sc !== 16'hFFFE) begin
          n_err++;
          $display("FAIL sat_approach: got stall=%0d want 65534", a.sc);
        end
      end
    end
    n_vec++;
    if (a.sc !== 16'hFFFF || a !== e) begin
      n_err++;
      $display("FAIL sat_hold: got %s want %s stall=65535", fmt(a), fmt(e));
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_six();
    test_illegal_ls();
    test_flush();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result/CDB data width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req_valid  input  6  result-ready requests; bit 0 ADD1, 1 ADD2, 2 ADD3, 3 MULT1, 4 MULT2, 5 LS.
REQ-005 SHALL have port req_data  input  6*DATA_W  results; slice i = bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port ls_idx  input  3  load/store buffer index of the LS request, legal 1..6.
REQ-007 SHALL have port flush  input  1  synchronous squash of the arbiter.
REQ-008 SHALL have port req_grant  output  6  one-hot-or-zero grant, combinational.
REQ-009 SHALL have port cdb_valid  output  1  CDB broadcast valid, registered.
REQ-010 SHALL have port cdb_tag  output  4  producer tag of the broadcast.
REQ-011 SHALL have port cdb_data  output  DATA_W  broadcast value.
REQ-012 SHALL have port stall_cnt  output  16  saturating contention counter.

Function
REQ-013 SHALL grant at most one eligible requester per cycle; the grant is combinational from req_valid, ls_idx, flush and the priority state.
REQ-014 LS eligibility SHALL require req_valid[5]=1 and ls_idx in 1..6; LS requests with ls_idx 0 or 7 SHALL never be granted.
REQ-015 A requester SHALL hold its valid and data stable until granted and SHALL deassert the cycle after grant; the arbiter SHALL NOT buffer ungranted requests.
REQ-016 On grant of requester i in cycle N, cycle N+1 SHALL present cdb_valid=1, cdb_data=req_data slice i sampled in cycle N, and the tag per REQ-017. Latency is exactly 1 cycle, and back-to-back broadcasts are allowed every cycle.
REQ-017 Tag mapping: ADD1=7, ADD2=8, ADD3=9, MULT1=10, MULT2=11, LS=ls_idx.
REQ-018 With no grant in cycle N, cycle N+1 SHALL show cdb_valid=0, cdb_tag=0 and cdb_data=0.
REQ-019 flush=1 SHALL force req_grant=0 in that cycle, cdb_valid=0 the next cycle, and the priority pointer to 0; stall_cnt is unaffected.
REQ-020 stall_cnt SHALL increment by 1 in each non-flush cycle with two or more eligible requesters, and SHALL saturate at 0xFFFF.

Reset
REQ-021 When rst_n=0 at a clock edge: cdb_valid=0, cdb_tag=0, cdb_data=0, stall_cnt=0, pointer=0; req_grant SHALL be 0 while rst_n=0.
REQ-022 Reset SHALL take priority over flush and over any request, including mid-stream; no broadcast SHALL follow a reset cycle.

Configuration
REQ-023 With macro CDB_ROUND_ROBIN_EN defined, the arbiter SHALL search from the 3-bit pointer upward, wrapping 5->0. After each grant of requester i the pointer SHALL become (i+1) mod 6. The pointer SHALL be unchanged with no grant.
REQ-024 Without CDB_ROUND_ROBIN_EN, the arbiter SHALL use fixed priority LS > MULT1 > MULT2 > ADD1 > ADD2 > ADD3; the pointer register SHALL be absent and flush SHALL affect only grant/CDB.

Structure
REQ-025 Shared package tomasulo_pkg SHALL hold tag constants TAG_ADD1..TAG_MULT2 (7..11), requester index constants REQ_ADD1..REQ_LS (0..5), NUM_REQ=6, and TAG_W=4.
REQ-026 Round-robin selection SHALL live in sub-module rr_picker (6-bit request, 3-bit pointer in, one-hot grant out), instantiated only under CDB_ROUND_ROBIN_EN.

Verification
REQ-027 Single request: ADD2 valid with data 0x0000_00AA at cycle 5 -> req_grant=6'b000010 at cycle 5; cycle 6 cdb_valid=1, tag 8, data 0xAA; cycle 7 cdb_valid=0.
REQ-028 All six requesting simultaneously (ls_idx=3), RR build -> grant order ADD1, ADD2, ADD3, MULT1, MULT2, LS over 6 cycles; tags 7, 8, 9, 10, 11, 3; stall_cnt=5. Fixed build -> LS first, tag 3.
REQ-029 Illegal LS: only LS valid with ls_idx=0 for 4 cycles -> req_grant=0 and cdb_valid=0 throughout; stall_cnt unchanged.
REQ-030 Flush: MULT1 and ADD3 valid, flush=1 -> no grant and no broadcast the next cycle. The following cycle (RR build, pointer 0) -> ADD3 granted; tag 9 then appears.
REQ-031 Reset mid-stream: grant in cycle N with rst_n=0 at that edge -> cycle N+1 has cdb_valid=0, stall_cnt=0, and the pointer restarts at ADD1.
REQ-032 Saturation: two requesters held continuously for 70000 cycles -> stall_cnt stops at 0xFFFF and does not wrap.
